vga_timing_gen: RTL

Parametrised VGA/DVI raster timing generator that replaces the fixed 640x480 sync block. It runs in a single clock domain: the vertical counter advances on the horizontal wrap, not on a derived sync edge. It adds a pixel clock-enable, configurable sync polarity, a data-enable output, and line/frame start strobes. It sits between the pixel clock source and the pixel/colour pipeline, and drives the monitor sync pins.

---
 rtl/vga_timing_gen.sv | 92 +++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA/DVI raster timing generator
// Counters sample position each enabled clock; outputs are the registered decode of that position.
module vga_timing_gen #(
   parameter int H_FP   = 16,
   parameter int H_SYNC = 96,
   parameter int H_BP   = 48,
   parameter int H_ACT  = 640,
   parameter int V_FP   = 10,
   parameter int V_SYNC = 2,
   parameter int V_BP   = 33,
   parameter int V_ACT  = 480,
   parameter int H_POL  = 0,
   parameter int V_POL  = 0,
   parameter int CW     = 11
) (
   input  logic          clk,
   input  logic          sync_rst,
   input  logic          ce,
   output logic          h_sync,
   output logic          v_sync,
   output logic          de,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          line_start,
   output logic          frame_start
);

   localparam int H_BLANK = H_FP + H_SYNC + H_BP;
   localparam int H_TOTAL = H_BLANK + H_ACT;
   localparam int V_BLANK = V_FP + V_SYNC + V_BP;
   localparam int V_TOTAL = V_BLANK + V_ACT;

   localparam logic [CW-1:0] H_SS   = CW'(H_FP);
   localparam logic [CW-1:0] H_SE   = CW'(H_FP + H_SYNC);
   localparam logic [CW-1:0] H_BL   = CW'(H_BLANK);
   localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_SS   = CW'(V_FP);
   localparam logic [CW-1:0] V_SE   = CW'(V_FP + V_SYNC);
   localparam logic [CW-1:0] V_BL   = CW'(V_BLANK);
   localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

   localparam logic H_ON = (H_POL != 0);
   localparam logic V_ON = (V_POL != 0);

   logic [CW-1:0] h;
   logic [CW-1:0] v;
   logic          h_act;
   logic          v_act;
   logic          hs_d;
   logic          vs_d;

   always_comb begin
      h_act = (h >= H_BL);
      v_act = (v >= V_BL);
      hs_d  = (h >= H_SS && h < H_SE) ? H_ON : ~H_ON;
      vs_d  = (v >= V_SS && v < V_SE) ? V_ON : ~V_ON;
   end

   always_ff @(posedge clk) begin
      if (sync_rst) begin
         h           <= '0;
         v           <= '0;
         h_sync      <= ~H_ON;
         v_sync      <= ~V_ON;
         de          <= 1'b0;
         x           <= '0;
         y           <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         // strobes drop on held clocks so each event is exactly one clock wide
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         if (ce) begin
            h_sync      <= hs_d;
            v_sync      <= vs_d;
            de          <= h_act && v_act;
            x           <= h_act ? h - H_BL : '0;
            y           <= v_act ? v - V_BL : '0;
            line_start  <= (h == '0);
            frame_start <= (h == '0) && (v == '0);
            if (h == H_LAST) begin
               h <= '0;
               v <= (v == V_LAST) ? '0 : v + 1'b1;
            end else begin
               h <= h + 1'b1;
            end
         end
      end
   end

endmodule
